// File: rtl/mc_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mc_seq_ctrl
// Purpose  : Multi-cycle MIPS sequencing controller (IF/ID/EX/MEM/WB) with
//            memory-handshake wait timeout and a sticky error trap.
// Revision : 1.0 - initial release
// ============================================================================
module mc_seq_ctrl #(
  parameter int MAX_WAIT = 16,
  parameter int ALUOP_W  = 5
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [5:0]         opcode,
  input  logic [5:0]         func,
  input  logic               zero,
  input  logic               mem_ack,
  output logic               imem_req,
  output logic               dmem_req,
  output logic               PCWrite,
  output logic               IRWrite,
  output logic               RegWrite,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               ALUSrc,
  output logic               ExtOp,
  output logic [1:0]         RegDst,
  output logic [1:0]         DatatoReg,
  output logic [1:0]         PC_sel,
  output logic [ALUOP_W-1:0] ALUCtrl,
  output logic [2:0]         state,
  output logic               illegal,
  output logic               err
);

  localparam logic [5:0] c_op_rtype = 6'b000000;
  localparam logic [5:0] c_op_ori   = 6'b001101;
  localparam logic [5:0] c_op_lui   = 6'b001111;
  localparam logic [5:0] c_op_slti  = 6'b001010;
  localparam logic [5:0] c_op_lw    = 6'b100011;
  localparam logic [5:0] c_op_sw    = 6'b101011;
  localparam logic [5:0] c_op_beq   = 6'b000100;
  localparam logic [5:0] c_op_bne   = 6'b000101;
  localparam logic [5:0] c_op_j     = 6'b000010;

  localparam logic [5:0] c_fn_add  = 6'b100000;
  localparam logic [5:0] c_fn_addu = 6'b100001;
  localparam logic [5:0] c_fn_sub  = 6'b100010;
  localparam logic [5:0] c_fn_subu = 6'b100011;
  localparam logic [5:0] c_fn_slt  = 6'b101010;

  localparam logic [ALUOP_W-1:0] c_aluop_nop = ALUOP_W'(0);
  localparam logic [ALUOP_W-1:0] c_aluop_lui = ALUOP_W'(1);
  localparam logic [ALUOP_W-1:0] c_aluop_add = ALUOP_W'(3);
  localparam logic [ALUOP_W-1:0] c_aluop_sub = ALUOP_W'(4);
  localparam logic [ALUOP_W-1:0] c_aluop_slt = ALUOP_W'(10);
  localparam logic [ALUOP_W-1:0] c_aluop_or  = ALUOP_W'(13);

  localparam logic [1:0] c_regdst_rt    = 2'b00;
  localparam logic [1:0] c_regdst_rd    = 2'b01;
  localparam logic [1:0] c_d2r_alu      = 2'b00;
  localparam logic [1:0] c_d2r_mem      = 2'b01;
  localparam logic [1:0] c_pcsel_newpc  = 2'b00;
  localparam logic [1:0] c_pcsel_branch = 2'b01;
  localparam logic [1:0] c_pcsel_jump   = 2'b10;

  localparam int c_cnt_w = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EX  = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4,
    S_ERR = 3'd5
  } state_t;

  state_t               r_state;
  logic [c_cnt_w-1:0]   r_wait;

  logic w_rtype, w_r_add, w_r_sub, w_r_slt, w_r_ok;
  logic w_ori, w_lui, w_slti, w_lw, w_sw, w_beq, w_bne, w_j;
  logic w_branch, w_ldst, w_legal, w_use_imm, w_zext, w_wait_done;
  logic [ALUOP_W-1:0] w_aluop;

  // The IR is only loaded in IF, so opcode/func stay stable from ID to WB.
  assign w_rtype   = (opcode == c_op_rtype);
  assign w_r_add   = w_rtype && (func == c_fn_add || func == c_fn_addu);
  assign w_r_sub   = w_rtype && (func == c_fn_sub || func == c_fn_subu);
  assign w_r_slt   = w_rtype && (func == c_fn_slt);
  assign w_r_ok    = w_r_add || w_r_sub || w_r_slt;
  assign w_ori     = (opcode == c_op_ori);
  assign w_lui     = (opcode == c_op_lui);
  assign w_slti    = (opcode == c_op_slti);
  assign w_lw      = (opcode == c_op_lw);
  assign w_sw      = (opcode == c_op_sw);
  assign w_beq     = (opcode == c_op_beq);
  assign w_bne     = (opcode == c_op_bne);
  assign w_j       = (opcode == c_op_j);
  assign w_branch  = w_beq || w_bne;
  assign w_ldst    = w_lw || w_sw;
  assign w_legal   = w_r_ok || w_ori || w_lui || w_slti || w_ldst || w_branch || w_j;
  assign w_use_imm = w_ori || w_lui || w_slti || w_ldst;
  assign w_zext    = w_ori || w_lui;
  assign w_wait_done = (r_wait == c_cnt_w'(MAX_WAIT - 1));

  always_comb begin
    w_aluop = c_aluop_add;
    if (w_r_sub || w_branch)     w_aluop = c_aluop_sub;
    else if (w_r_slt || w_slti)  w_aluop = c_aluop_slt;
    else if (w_ori)              w_aluop = c_aluop_or;
    else if (w_lui)              w_aluop = c_aluop_lui;
  end

  // The wait counter clears on every transition and only advances while a
  // request sits unacknowledged in IF or MEM.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_IF;
      r_wait  <= '0;
    end else begin
      r_wait <= '0;
      case (r_state)
        S_IF: begin
          if (mem_ack)          r_state <= S_ID;
          else if (w_wait_done) r_state <= S_ERR;
          else                  r_wait  <= r_wait + c_cnt_w'(1);
        end
        S_ID:  r_state <= (w_j || !w_legal) ? S_IF : S_EX;
        S_EX: begin
          if (w_branch)    r_state <= S_IF;
          else if (w_ldst) r_state <= S_MEM;
          else             r_state <= S_WB;
        end
        S_MEM: begin
          if (mem_ack)          r_state <= w_lw ? S_WB : S_IF;
          else if (w_wait_done) r_state <= S_ERR;
          else                  r_wait  <= r_wait + c_cnt_w'(1);
        end
        S_WB:    r_state <= S_IF;
        S_ERR:   r_state <= S_ERR;
        default: r_state <= S_IF;
      endcase
    end
  end

  // Reset parks the FSM in IF, so the fetch outputs are qualified by rstn to
  // keep every request and enable low while reset is held.
  always_comb begin
    imem_req  = 1'b0;
    dmem_req  = 1'b0;
    PCWrite   = 1'b0;
    IRWrite   = 1'b0;
    RegWrite  = 1'b0;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    ALUSrc    = 1'b0;
    ExtOp     = 1'b0;
    RegDst    = c_regdst_rt;
    DatatoReg = c_d2r_alu;
    PC_sel    = c_pcsel_newpc;
    ALUCtrl   = c_aluop_nop;
    illegal   = 1'b0;
    err       = 1'b0;
    case (r_state)
      S_IF: begin
        imem_req = rstn;
        IRWrite  = rstn && mem_ack;
        PCWrite  = rstn && mem_ack;
      end
      S_ID: begin
        if (w_j) begin
          PCWrite = 1'b1;
          PC_sel  = c_pcsel_jump;
        end else if (!w_legal) begin
          illegal = 1'b1;
        end
      end
      S_EX: begin
        ALUSrc  = w_use_imm;
        ExtOp   = !w_zext;
        ALUCtrl = w_aluop;
        RegDst  = w_r_ok ? c_regdst_rd : c_regdst_rt;
        if (w_branch) begin
          PC_sel  = c_pcsel_branch;
          PCWrite = w_beq ? zero : !zero;
        end
      end
      S_MEM: begin
        dmem_req = 1'b1;
        MemRead  = w_lw;
        MemWrite = w_sw;
      end
      S_WB: begin
        RegWrite  = 1'b1;
        DatatoReg = w_lw ? c_d2r_mem : c_d2r_alu;
        RegDst    = w_r_ok ? c_regdst_rd : c_regdst_rt;
      end
      S_ERR:   err = 1'b1;
      default: ;
    endcase
  end

  assign state = r_state;

endmodule
`default_nettype wire

// File: tb/tb_mc_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mc_seq_ctrl
// Purpose  : Random instruction stream for mc_seq_ctrl, each instruction
//            expanded into its expected per-cycle phase list.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mc_seq_ctrl;

  localparam int MAX_WAIT = 16;

  localparam logic [2:0] ST_IF = 3'd0, ST_ID = 3'd1, ST_EX = 3'd2,
                         ST_MEM = 3'd3, ST_WB = 3'd4, ST_ERR = 3'd5;

  typedef struct packed {
    logic       imem, dmem, pcw, irw, rw, mr, mw, asrc, ext, ill, er;
    logic [1:0] rd, d2r, pcs;
    logic [4:0] alu;
  } outs_t;

  typedef struct {
    logic [2:0] st;
    logic       ack;
    outs_t      e;
  } cyc_t;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic [5:0] opcode = '0;
  logic [5:0] func = '0;
  logic       zero = 1'b0;
  logic       mem_ack = 1'b0;
  logic       imem_req, dmem_req, PCWrite, IRWrite, RegWrite, MemRead, MemWrite;
  logic       ALUSrc, ExtOp, illegal, err;
  logic [1:0] RegDst, DatatoReg, PC_sel;
  logic [4:0] ALUCtrl;
  logic [2:0] state;

  int n_checks = 0;
  int n_pass   = 0;
  cyc_t q[$];

  logic [5:0] legal_ops [8] = '{6'h0d, 6'h0f, 6'h0a, 6'h23, 6'h2b, 6'h04, 6'h05, 6'h02};
  logic [5:0] r_fns     [5] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h2a};
  logic [5:0] bad_fns   [4] = '{6'h00, 6'h24, 6'h25, 6'h08};
  logic [5:0] bad_ops   [5] = '{6'h3f, 6'h08, 6'h01, 6'h20, 6'h0c};

  mc_seq_ctrl #(.MAX_WAIT(MAX_WAIT), .ALUOP_W(5)) dut (
    .clk(clk), .rstn(rstn), .opcode(opcode), .func(func), .zero(zero),
    .mem_ack(mem_ack), .imem_req(imem_req), .dmem_req(dmem_req),
    .PCWrite(PCWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
    .MemRead(MemRead), .MemWrite(MemWrite), .ALUSrc(ALUSrc), .ExtOp(ExtOp),
    .RegDst(RegDst), .DatatoReg(DatatoReg), .PC_sel(PC_sel),
    .ALUCtrl(ALUCtrl), .state(state), .illegal(illegal), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  function automatic outs_t observe();
    return {imem_req, dmem_req, PCWrite, IRWrite, RegWrite, MemRead, MemWrite,
            ALUSrc, ExtOp, illegal, err, RegDst, DatatoReg, PC_sel, ALUCtrl};
  endfunction

  // Expands one instruction into the phase sequence the controller must walk.
  task automatic build(input logic [5:0] op, input logic [5:0] fn, input logic z,
                       input int dif, input int dmw);
    bit    is_r, r_ok, lw, sw, beq, bne, jj, ori, lui, slti, legal;
    outs_t e;
    logic [4:0] alu;
    is_r  = (op == 6'h00);
    r_ok  = is_r && (fn == 6'h20 || fn == 6'h21 || fn == 6'h22 || fn == 6'h23 || fn == 6'h2a);
    lw    = (op == 6'h23);  sw   = (op == 6'h2b);
    beq   = (op == 6'h04);  bne  = (op == 6'h05);
    jj    = (op == 6'h02);  ori  = (op == 6'h0d);
    lui   = (op == 6'h0f);  slti = (op == 6'h0a);
    legal = r_ok || lw || sw || beq || bne || jj || ori || lui || slti;
    if (r_ok)            alu = (fn == 6'h22 || fn == 6'h23) ? 5'd4 : (fn == 6'h2a) ? 5'd10 : 5'd3;
    else if (ori)        alu = 5'd13;
    else if (lui)        alu = 5'd1;
    else if (slti)       alu = 5'd10;
    else if (beq || bne) alu = 5'd4;
    else                 alu = 5'd3;
    q.delete();
    for (int i = 0; i <= dif; i++) begin
      e = '0; e.imem = 1'b1; e.pcw = (i == dif); e.irw = (i == dif);
      q.push_back('{ST_IF, (i == dif), e});
    end
    e = '0; e.pcw = jj; e.pcs = jj ? 2'b10 : 2'b00; e.ill = !legal;
    q.push_back('{ST_ID, 1'($urandom_range(0, 1)), e});
    if (legal && !jj) begin
      e = '0;
      e.asrc = ori || lui || slti || lw || sw;
      e.ext  = !(ori || lui);
      e.rd   = r_ok ? 2'b01 : 2'b00;
      e.alu  = alu;
      if (beq || bne) begin
        e.pcs = 2'b01;
        e.pcw = beq ? z : !z;
      end
      q.push_back('{ST_EX, 1'($urandom_range(0, 1)), e});
      if (lw || sw) begin
        for (int i = 0; i <= dmw; i++) begin
          e = '0; e.dmem = 1'b1; e.mr = lw; e.mw = sw;
          q.push_back('{ST_MEM, (i == dmw), e});
        end
      end
      if (lw || (!sw && !beq && !bne)) begin
        e = '0; e.rw = 1'b1; e.d2r = lw ? 2'b01 : 2'b00; e.rd = r_ok ? 2'b01 : 2'b00;
        q.push_back('{ST_WB, 1'($urandom_range(0, 1)), e});
      end
    end
  endtask

  // Entered and left at posedge+1; inputs driven early in the cycle, outputs checked 2 later.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                           input int dif, input int dmw);
    build(op, fn, z, dif, dmw);
    opcode = op; func = fn; zero = z;
    foreach (q[k]) begin
      mem_ack = q[k].ack;
      #2;
      chk($sformatf("state op%0h c%0d", op, k), 32'(state), 32'(q[k].st));
      chk($sformatf("outs op%0h c%0d", op, k), 32'(observe()), 32'(q[k].e));
      @(posedge clk); #1;
    end
    mem_ack = 1'b0;
  endtask

  initial begin
    logic [5:0] op, fn;
    outs_t      e0;
    int         sel;

    // Reset held: everything quiet even though the FSM sits in IF.
    #12;
    chk("rst_state", 32'(state), 32'(ST_IF));
    chk("rst_outs", 32'(observe()), 32'h0);
    @(posedge clk); #1;
    rstn = 1'b1;

    // Directed cases.
    run_instr(6'h00, 6'h21, 1'b0, 0, 0);   // addu
    run_instr(6'h23, 6'h00, 1'b0, 0, 3);   // lw, 3-cycle ack delay
    run_instr(6'h04, 6'h00, 1'b1, 0, 0);   // beq taken
    run_instr(6'h04, 6'h00, 1'b0, 0, 0);   // beq not taken
    run_instr(6'h3f, 6'h00, 1'b0, 0, 0);   // illegal opcode
    run_instr(6'h02, 6'h00, 1'b0, 0, 0);   // j
    run_instr(6'h2b, 6'h00, 1'b0, 2, 1);   // sw
    run_instr(6'h05, 6'h00, 1'b0, 1, 0);   // bne taken
    run_instr(6'h00, 6'h05, 1'b0, 0, 0);   // bad funct

    // Random stream with short handshake delays.
    for (int n = 0; n < 80; n++) begin
      sel = $urandom_range(0, 11);
      fn  = 6'($urandom);
      if (sel == 0)       begin op = 6'h00; fn = r_fns[$urandom_range(0, 4)]; end
      else if (sel == 1)  begin op = 6'h00; fn = bad_fns[$urandom_range(0, 3)]; end
      else if (sel == 11) op = bad_ops[$urandom_range(0, 4)];
      else                op = legal_ops[$urandom_range(0, 7)];
      run_instr(op, fn, 1'($urandom_range(0, 1)), $urandom_range(0, 4), $urandom_range(0, 4));
    end
    chk("end_state", 32'(state), 32'(ST_IF));

    // Fetch never acknowledged: trap after MAX_WAIT cycles, then sticky.
    opcode = 6'h00; func = 6'h20;
    for (int i = 0; i < MAX_WAIT; i++) begin
      mem_ack = 1'b0; #2;
      chk($sformatf("wait_if c%0d", i), 32'(state), 32'(ST_IF));
      @(posedge clk); #1;
    end
    e0 = '0; e0.er = 1'b1;
    for (int i = 0; i < 4; i++) begin
      mem_ack = 1'b1; #2;
      chk($sformatf("err_state c%0d", i), 32'(state), 32'(ST_ERR));
      chk($sformatf("err_outs c%0d", i), 32'(observe()), 32'(e0));
      @(posedge clk); #1;
    end
    rstn = 1'b0; mem_ack = 1'b0; #1;
    chk("err_clear", 32'(err), 32'h0);
    @(posedge clk); #1;
    rstn = 1'b1;

    // Reset asserted mid-store: MemWrite must drop without waiting for a clock.
    opcode = 6'h2b; func = 6'h00;
    mem_ack = 1'b1; @(posedge clk); #1;
    mem_ack = 1'b0; @(posedge clk); #1;
    @(posedge clk); #1;
    #1;
    chk("sw_mem_state", 32'(state), 32'(ST_MEM));
    chk("sw_memwrite", 32'(MemWrite), 32'h1);
    rstn = 1'b0; #1;
    chk("abort_memwrite", 32'(MemWrite), 32'h0);
    chk("abort_dmem", 32'(dmem_req), 32'h0);
    chk("abort_state", 32'(state), 32'(ST_IF));
    @(posedge clk); #1;
    rstn = 1'b1; #1;
    chk("post_rst_state", 32'(state), 32'(ST_IF));
    chk("post_rst_imem", 32'(imem_req), 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
